// File: rtl/term_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// term_uart_tx_sched
//
// Shares one 8N1 terminal UART transmitter between NREQ byte requesters.
// In IDLE a round-robin arbiter picks the first requester with req_valid set,
// starting at rr_ptr, and acknowledges it with a one-cycle req_ready pulse.
// The byte is then sent as START, DATA (LSB first), STOP, each bit lasting
// BAUD_DIV clocks, and the FSM returns to IDLE for at least one cycle.
//
// Optional feature (macro TERM_UART_PKT_LOCK_EN): packet lock. Any accepted
// byte other than 8'h0A locks arbitration to its requester until that
// requester sends 8'h0A or stays silent for LOCK_TMO consecutive IDLE cycles.
// With the lock enabled, rr_ptr only advances when a lock is released.
// Without the macro, arbitration is per byte and no lock logic exists.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]     per-requester byte valid
//   req_data   in   [NREQ*8]   per-requester byte, requester i on [8i+7:8i]
//   req_ready  out  [NREQ]     one-hot, combinational acceptance in IDLE
//   uart_tx    out  serial line, idle high
//   busy       out  high during START/DATA/STOP
//   gnt_id     out  [3]        requester of the current / most recent frame
// -----------------------------------------------------------------------------
module term_uart_tx_sched #(
    parameter int NREQ     = 4,
    parameter int BAUD_DIV = 234,
    parameter int LOCK_TMO = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_tx,
    output logic              busy,
    output logic [2:0]        gnt_id
);

    generate
        if (NREQ < 2 || NREQ > 8 || BAUD_DIV < 2 || LOCK_TMO < 1) begin : g_param_check
            $error("term_uart_tx_sched: parameter out of range");
        end
    endgenerate

    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          busy_q;
    logic [2:0]    gnt_id_q;
    logic [2:0]    rr_ptr_q;

`ifdef TERM_UART_PKT_LOCK_EN
    localparam int            TW       = $clog2(LOCK_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TMO - 1);

    logic          lock_q;
    logic [2:0]    owner_q;
    logic [TW-1:0] tmo_q;
`endif

    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [7:0] grant_byte;

    function automatic logic [2:0] ptr_next(input logic [2:0] p);
        if (p == 3'(NREQ - 1)) return 3'd0;
        return p + 3'd1;
    endfunction

    // Arbiter: scan from rr_ptr; descending loop so the lowest offset wins.
    always_comb begin : arbiter
        logic [3:0] idx;
        logic       scan_en;
        idx       = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_en   = (state_q == IDLE);
`ifdef TERM_UART_PKT_LOCK_EN
        // A held lock restricts the candidate set to the owner alone.
        if (lock_q) begin
            scan_en = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (state_q == IDLE && owner_q == 3'(i) && req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = owner_q;
                end
            end
        end
`endif
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + 4'(k);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (scan_en && idx == 4'(i) && req_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin
        grant_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 3'(i)) grant_byte = req_data[8*i +: 8];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_vld && (grant_idx == 3'(i));
        end
    end

    // Frame FSM; uart_tx and busy are registered so reset forces them
    // to the idle line state immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            gnt_id_q <= '0;
            rr_ptr_q <= '0;
`ifdef TERM_UART_PKT_LOCK_EN
            lock_q   <= 1'b0;
            owner_q  <= '0;
            tmo_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (grant_vld) begin
                        shreg_q  <= grant_byte;
                        gnt_id_q <= grant_idx;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
`ifdef TERM_UART_PKT_LOCK_EN
                        tmo_q <= '0;
                        // Line feed ends the packet; nothing else can be
                        // granted during the frame, so releasing now is
                        // equivalent to releasing after it.
                        if (grant_byte == 8'h0A) begin
                            lock_q   <= 1'b0;
                            rr_ptr_q <= ptr_next(grant_idx);
                        end else begin
                            lock_q  <= 1'b1;
                            owner_q <= grant_idx;
                        end
`else
                        rr_ptr_q <= ptr_next(grant_idx);
`endif
                    end
`ifdef TERM_UART_PKT_LOCK_EN
                    else if (lock_q) begin
                        // No grant while locked means the owner is silent.
                        if (tmo_q == TMO_LAST) begin
                            lock_q   <= 1'b0;
                            tmo_q    <= '0;
                            rr_ptr_q <= ptr_next(owner_q);
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
`endif
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // shreg_q[0] is the bit on the line; shift next in.
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shreg_q[1];
                            shreg_q <= shreg_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign gnt_id  = gnt_id_q;

endmodule

// File: tb/tb_term_uart_tx_sched.sv
// Scoreboard bench for term_uart_tx_sched (NREQ=4, BAUD_DIV=4, LOCK_TMO=16).
// Stimulus pushes hand-chosen expected frames {requester, byte}; a monitor
// decodes every frame on uart_tx and compares it against the queue head.
module tb_term_uart_tx_sched;
    localparam int NREQ  = 4;
    localparam int BD    = 4;
    localparam int TMO   = 16;
    localparam int FRAME = 10 * BD;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              uart_tx;
    logic              busy;
    logic [2:0]        gnt_id;

    term_uart_tx_sched #(.NREQ(NREQ), .BAUD_DIV(BD), .LOCK_TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] b;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    exp_t       sb[$];
    int         starts[$];
    logic [7:0] src_mem [NREQ][8];
    int         src_head [NREQ];
    int         src_tail [NREQ];
    logic [NREQ-1:0] glitch;
    logic [7:0] glitch_data [NREQ];
    int         ready_cnt [NREQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [FRAME-1:0] pattern(input logic [7:0] b);
        logic [9:0]       w;
        logic [FRAME-1:0] r;
        w = {1'b1, b, 1'b0};
        for (int c = 0; c < FRAME; c++) r[c] = w[c / BD];
        return r;
    endfunction

    task automatic load(input int id, input logic [7:0] b);
        if (src_head[id] == src_tail[id]) begin
            src_head[id] = 0;
            src_tail[id] = 0;
        end
        src_mem[id][src_tail[id]] = b;
        src_tail[id]++;
    endtask

    task automatic expect_frame(input int id, input logic [7:0] b);
        exp_t e;
        e.id = 3'(id);
        e.b  = b;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy(input string name, input int maxc);
        int n;
        n = 0;
        while (!busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b1);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n;
        n = 0;
        while ((sb.size() > 0 || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        idle(2);
        chk(name, (sb.size() == 0) && !busy, 1'b1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester driver: presents queued bytes, retires one per handshake.
    initial begin : driver
        logic [NREQ-1:0] hs;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("ready_onehot", ($countones(req_ready) <= 1) && !(busy && (req_ready != '0)), 1'b1);
            end
            hs = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) ready_cnt[i]++;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && src_head[i] < src_tail[i]) src_head[i]++;
                if (src_head[i] < src_tail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_mem[i][src_head[i]];
                end else begin
                    req_valid[i]       = glitch[i];
                    req_data[8*i +: 8] = glitch_data[i];
                end
            end
        end
    end

    // Monitor: decodes each frame and checks it against the scoreboard.
    initial begin : monitor
        logic             prev_b;
        logic             busy_ok;
        logic             aborted;
        logic [2:0]       id0;
        logic [FRAME-1:0] act;
        exp_t             e;
        prev_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && busy && !prev_b) begin
                starts.push_back(cyc);
                id0     = gnt_id;
                busy_ok = 1'b1;
                aborted = 1'b0;
                act     = '0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    act[c] = uart_tx;
                    if (!busy) busy_ok = 1'b0;
                end
                if (aborted) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                end else begin
                    @(negedge clk);
                    chk("frame_end_idle", {busy, uart_tx}, 2'b01);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got gnt_id=%0d line=%h, required no frame", id0, act);
                    end else begin
                        e = sb.pop_front();
                        chk("frame_line", act, pattern(e.b));
                        chk("frame_gnt_id", id0, e.id);
                        chk("frame_busy", busy_ok, 1'b1);
                    end
                end
            end
            prev_b = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required test end");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] t4b [2][4];
        t4b = '{'{8'h12, 8'h34, 8'h56, 8'h78}, '{8'h9A, 8'hBC, 8'hDE, 8'hF0}};
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        glitch    = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_head[i]    = 0;
            src_tail[i]    = 0;
            glitch_data[i] = 8'h00;
            ready_cnt[i]   = 0;
        end

        // Reset state
        idle(3);
        chk("rst_uart_tx", uart_tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_gnt_id", gnt_id, 3'd0);
        rst_n = 1'b1;

        // No requests: stay idle
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("idle_line", {busy, uart_tx}, 2'b01);
        end

        // Only req3 valid with rr_ptr=0
        load(3, 8'hC3);
        expect_frame(3, 8'hC3);
        wait_drain("req3_drain", 300);
        idle(40);

`ifndef TERM_UART_PKT_LOCK_EN
        // All four valid: per-byte round robin, 41-cycle frame spacing
        starts.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) begin
                load(i, t4b[r][i]);
                expect_frame(i, t4b[r][i]);
            end
        wait_drain("rr_drain", 1500);
        chk("rr_frame_count", starts.size(), 8);
        for (int k = 0; k + 1 < starts.size(); k++)
            chk("rr_frame_gap", starts[k+1] - starts[k], FRAME + 1);
`else
        // Packet lock: req1 sends "AB\n" while req2 is waiting
        starts.delete();
        load(1, 8'h41); load(1, 8'h42); load(1, 8'h0A); load(2, 8'h55);
        expect_frame(1, 8'h41); expect_frame(1, 8'h42);
        expect_frame(1, 8'h0A); expect_frame(2, 8'h55);
        wait_drain("lock_drain", 2000);
        chk("lock_frame_count", starts.size(), 4);
        if (starts.size() == 4)
            for (int k = 0; k < 3; k++)
                chk("lock_frame_gap", starts[k+1] - starts[k], FRAME + 1);
        idle(40);

        // Lock timeout: req2 waits LOCK_TMO idle cycles
        starts.delete();
        load(1, 8'h41);
        expect_frame(1, 8'h41);
        wait_busy("tmo_busy", 100);
        load(2, 8'h66);
        expect_frame(2, 8'h66);
        wait_drain("tmo_drain", 2000);
        chk("tmo_frame_count", starts.size(), 2);
        if (starts.size() == 2)
            chk("tmo_gap", starts[1] - starts[0], FRAME + 1 + TMO);
        idle(40);
`endif

        // Req0 sends 8'h41; req1 raises and drops valid mid-frame
        for (int i = 0; i < NREQ; i++) ready_cnt[i] = 0;
        load(0, 8'h41);
        expect_frame(0, 8'h41);
        wait_busy("a_busy", 100);
        glitch_data[1] = 8'h77;
        glitch[1]      = 1'b1;
        idle(10);
        glitch[1]      = 1'b0;
        wait_drain("a_drain", 300);
        idle(60);
        chk("a_ready0_pulses", ready_cnt[0], 1);
        chk("a_ready1_pulses", ready_cnt[1], 0);

        // Reset during a frame aborts it; rr_ptr restarts at 0
        load(0, 8'h96);
        expect_frame(0, 8'h96);
        wait_busy("abort_busy", 100);
        idle(14);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_uart_tx", uart_tx, 1'b1);
        chk("abort_busy_low", busy, 1'b0);
        idle(3);
        chk("abort_req_ready", req_ready, 4'b0000);
        chk("abort_gnt_id", gnt_id, 3'd0);
        rst_n = 1'b1;
        load(1, 8'hA5);
        load(0, 8'h5A);
        expect_frame(0, 8'h5A);
        expect_frame(1, 8'hA5);
        wait_drain("post_rst_drain", 2000);
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/term_uart_tx_sched.md
TERM_UART_TX_SCHED -- requirements
Module: term_uart_tx_sched

Interface
- REQ-001: Parameter NREQ, default 4: number of byte requesters sharing the terminal UART transmitter (2..8).
- REQ-002: Parameter BAUD_DIV, default 234: clock cycles per UART bit (27 MHz / 115200).
- REQ-003: Parameter LOCK_TMO, default 4096: idle cycles after which a packet lock is abandoned.
- REQ-004: clk  in  1  single clock; all state on rising edge.
- REQ-005: rst_n  in  1  asynchronous active-low reset.
- REQ-006: req_valid  in  NREQ  per-requester byte-valid.
- REQ-007: req_data  in  NREQ*8  per-requester byte; requester i on bits [8i+7:8i].
- REQ-008: req_ready  out  NREQ  one-hot acceptance pulse; a byte transfers when valid and ready are both high.
- REQ-009: uart_tx  out  1  serial line, idle high, 8N1, LSB first.
- REQ-010: busy  out  1  high while a frame is on the line (START/DATA/STOP).
- REQ-011: gnt_id  out  3  index of the requester owning the current or most recent frame.

Function
- REQ-012: The FSM SHALL have states IDLE, START, DATA, STOP.
- REQ-013: In IDLE, it SHALL grant the first requester with req_valid=1, searching round-robin from pointer rr_ptr; req_ready for that requester SHALL be high combinationally in that cycle only.
- REQ-014: On acceptance, it SHALL latch the byte, set gnt_id, set rr_ptr=(grant+1) mod NREQ, and enter START on the next edge.
- REQ-015: START SHALL drive uart_tx=0 for BAUD_DIV cycles.
- REQ-016: DATA SHALL drive data bits 0..7 for BAUD_DIV cycles each.
- REQ-017: STOP SHALL drive uart_tx=1 for BAUD_DIV cycles, then return to IDLE.
- REQ-018: A frame SHALL occupy exactly 10*BAUD_DIV cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle.
- REQ-019: req_ready SHALL be all-zero outside IDLE, and SHALL never have more than one bit set.
- REQ-020: The bit counter SHALL count 0..7 and the baud counter 0..BAUD_DIV-1, each wrapping to 0 with no off-by-one at bit boundaries.
- REQ-021: A requester dropping req_valid before acceptance SHALL lose no data and cause no grant.
- REQ-022: With no valid requests, the block SHALL remain in IDLE with uart_tx=1 and busy=0.

Reset
- REQ-023: While rst_n=0, outputs SHALL be: uart_tx=1, busy=0, req_ready=0, gnt_id=0. State SHALL be IDLE, rr_ptr=0, all counters=0, lock cleared.
- REQ-024: Reset asserted mid-frame SHALL abort the frame immediately (uart_tx=1 asynchronously); the aborted byte SHALL NOT be retransmitted.

Configuration
- REQ-025: Macro TERM_UART_PKT_LOCK_EN SHALL enable packet lock; without the macro, arbitration SHALL be per byte and the lock logic SHALL be absent.
- REQ-026: With the macro, accepting a byte other than 8'h0A SHALL lock the grant to that requester, and IDLE SHALL consider only the lock owner.
- REQ-027: With the macro, accepting 8'h0A SHALL release the lock after that frame.
- REQ-028: With the macro, LOCK_TMO consecutive IDLE cycles without owner valid SHALL also release the lock.
- REQ-029: With the macro, rr_ptr SHALL advance only on lock release.

Verification (BAUD_DIV=4, NREQ=4)
- REQ-030: Req0 sends 8'h41 → uart_tx is 0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy is high for 40 cycles; req_ready[0] pulses once.
- REQ-031: Req0..3 all valid continuously, no macro → grants in order 0,1,2,3,0; frames 41 cycles apart.
- REQ-032: With macro, req1 sends "AB\n" while req2 is valid throughout → the line carries 41,42,0A from req1 before req2's first byte; gnt_id is 1 for three frames.
- REQ-033: With macro, req1 sends 8'h41 then goes idle → req2 is granted exactly LOCK_TMO+1 cycles after STOP ends.
- REQ-034: rst_n pulled low at cycle 15 of a frame → uart_tx=1 and busy=0 within the same cycle; after release, the next grant goes to req0.
- REQ-035: Req3 valid only, rr_ptr=0 → req3 granted in the first IDLE cycle; rr_ptr then equals 0.
